ecc_scrub_ctrl: RTL

- Background scrubber and port sharer for the Hamming-protected RAM port.
- Walks every RAM word at a programmable rate, recomputes the SEC syndrome, writes corrected codewords back, and counts and reports errors.
- Shares one RAM port between the user path and the scrubber. The user always has priority; the scrubber only uses idle cycles.
- Codeword layout: parity bits at 1-based power-of-two positions, data bits fill the remaining positions LSB-first. P is the smallest value with 2^P >= DATA_WIDTH+P+1.

---
 rtl/ecc_scrub_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl
//   Background scrubber for a Hamming (SEC) protected RAM. It walks addresses
//   0..DEPTH-1 at a programmable idle rate, recomputes each word's syndrome,
//   writes back corrected codewords and reports errors. It also shares the
//   single RAM port with the user path. The user always wins and is never
//   stalled; the scrubber only uses cycles where user_req is low.
//
//   Optional build macro: ECC_SCRUB_STATS_EN
//     When defined, the corr_cnt and uncorr_cnt counters and the err_addr
//     register are built. When undefined, those outputs are tied to 0.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   scrub_en                enable the scrubber (low = pure pass-through)
//   user_req/we/addr/wdata  user RAM access, forwarded to mem_* in the same cycle
//   user_rdata              mem_rdata pass-through
//   mem_req/we/addr/wdata   shared RAM port
//   mem_rdata               RAM read data, READ_LATENCY cycles after a read
//   scrub_busy              high in every state except IDLE
//   err_valid/err_uncorr    one-cycle error pulse; err_uncorr=1 means uncorrectable
//   err_addr                address of the most recently reported error
//   pass_done               one-cycle pulse when the address wraps to 0
//   corr_cnt/uncorr_cnt     saturating error counters
module ecc_scrub_ctrl #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 8,
   parameter int DEPTH          = 256,
   parameter int SCRUB_INTERVAL = 1024,
   parameter int READ_LATENCY   = 1,
   // smallest P with 2^P >= DATA_WIDTH+P+1
   localparam int P = (DATA_WIDTH <= 1)   ? 2 :
                      (DATA_WIDTH <= 4)   ? 3 :
                      (DATA_WIDTH <= 11)  ? 4 :
                      (DATA_WIDTH <= 26)  ? 5 :
                      (DATA_WIDTH <= 57)  ? 6 :
                      (DATA_WIDTH <= 120) ? 7 :
                      (DATA_WIDTH <= 247) ? 8 :
                      (DATA_WIDTH <= 502) ? 9 : 10,
   localparam int CODE_WIDTH = DATA_WIDTH + P
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  scrub_en,
   input  logic                  user_req,
   input  logic                  user_we,
   input  logic [ADDR_WIDTH-1:0] user_addr,
   input  logic [CODE_WIDTH-1:0] user_wdata,
   output logic [CODE_WIDTH-1:0] user_rdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [CODE_WIDTH-1:0] mem_wdata,
   input  logic [CODE_WIDTH-1:0] mem_rdata,
   output logic                  scrub_busy,
   output logic                  err_valid,
   output logic                  err_uncorr,
   output logic [ADDR_WIDTH-1:0] err_addr,
   output logic                  pass_done,
   output logic [15:0]           corr_cnt,
   output logic [15:0]           uncorr_cnt
);

   localparam int IW = $clog2(SCRUB_INTERVAL + 1);
   localparam int LW = $clog2(READ_LATENCY + 1);
   localparam logic [IW-1:0]         INT_RELOAD = IW'(SCRUB_INTERVAL - 1);
   localparam logic [LW-1:0]         LAT_RELOAD = LW'(READ_LATENCY - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_CHK, S_WB, S_NEXT} state_t;

   state_t                  state;
   logic [IW-1:0]           int_cnt;
   logic [LW-1:0]           lat_cnt;
   logic [ADDR_WIDTH-1:0]   scrub_addr;
   logic [CODE_WIDTH-1:0]   word;
   logic [P-1:0]            syn;
   logic                    correctable;
   logic [CODE_WIDTH-1:0]   flip_mask;
   logic                    abort;

   // XOR of the 1-based indices of all set bits
   function automatic logic [P-1:0] syndrome(input logic [CODE_WIDTH-1:0] w);
      logic [P-1:0] s;
      s = '0;
      for (int i = 0; i < CODE_WIDTH; i++)
         if (w[i]) s = s ^ P'(i + 1);
      return s;
   endfunction

   assign syn         = syndrome(word);
   assign correctable = (syn != '0) && (int'(syn) <= CODE_WIDTH);
   assign flip_mask   = CODE_WIDTH'(1) << (syn - 1'b1);

   // A user write to the word in flight makes our copy stale: drop it and re-read.
   assign abort = user_req && user_we && (user_addr == scrub_addr) &&
                  (state == S_WAIT || state == S_CHK || state == S_WB);

   assign scrub_busy = (state != S_IDLE);
   assign user_rdata = mem_rdata;

   // Port mux: user has absolute priority, scrubber fills idle cycles.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (user_req) begin
         mem_req   = 1'b1;
         mem_we    = user_we;
         mem_addr  = user_addr;
         mem_wdata = user_wdata;
      end else if (state == S_RD) begin
         mem_req   = 1'b1;
         mem_addr  = scrub_addr;
      end else if (state == S_WB) begin
         mem_req   = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = scrub_addr;
         mem_wdata = word;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         int_cnt    <= INT_RELOAD;
         lat_cnt    <= LAT_RELOAD;
         scrub_addr <= '0;
         word       <= '0;
         err_valid  <= 1'b0;
         err_uncorr <= 1'b0;
         pass_done  <= 1'b0;
      end else begin
         err_valid  <= 1'b0;
         err_uncorr <= 1'b0;
         pass_done  <= 1'b0;
         case (state)
            S_IDLE:
               if (scrub_en) begin
                  if (int_cnt == '0) begin
                     int_cnt <= INT_RELOAD;
                     state   <= S_RD;
                  end else begin
                     int_cnt <= int_cnt - 1'b1;
                  end
               end
            S_RD:
               if (!user_req) begin
                  lat_cnt <= LAT_RELOAD;
                  state   <= S_WAIT;
               end
            // capture is positional: user reads in WAIT never shift it
            S_WAIT:
               if (abort) state <= S_RD;
               else if (lat_cnt == '0) begin
                  word  <= mem_rdata;
                  state <= S_CHK;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            S_CHK:
               if (abort) state <= S_RD;
               else if (syn == '0) state <= S_NEXT;
               else if (correctable) begin
                  word      <= word ^ flip_mask;
                  err_valid <= 1'b1;
                  state     <= S_WB;
               end else begin
                  err_valid  <= 1'b1;
                  err_uncorr <= 1'b1;
                  state      <= S_NEXT;
               end
            S_WB:
               if (abort) state <= S_RD;
               else if (!user_req) state <= S_NEXT;
            S_NEXT: begin
               if (scrub_addr == LAST_ADDR) begin
                  scrub_addr <= '0;
                  pass_done  <= 1'b1;
               end else begin
                  scrub_addr <= scrub_addr + 1'b1;
               end
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef ECC_SCRUB_STATS_EN
   logic chk_err;
   assign chk_err = (state == S_CHK) && !abort && (syn != '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
         err_addr   <= '0;
      end else if (chk_err) begin
         err_addr <= scrub_addr;
         if (correctable) begin
            if (corr_cnt != 16'hFFFF) corr_cnt <= corr_cnt + 1'b1;
         end else begin
            if (uncorr_cnt != 16'hFFFF) uncorr_cnt <= uncorr_cnt + 1'b1;
         end
      end
   end
`else
   assign corr_cnt   = '0;
   assign uncorr_cnt = '0;
   assign err_addr   = '0;
`endif

endmodule
